// File: rtl/panel_power_sequencer.sv
// Power/backlight sequencer for the LVDS LCD panel: orders link enable, backlight enable
// and backlight PWM on power-up/power-down, and generates the brightness PWM.
module panel_power_sequencer #(
    parameter int unsigned T_LINK   = 100_000,
    parameter int unsigned T_BL     = 50_000,
    parameter int unsigned T_OFF    = 500_000,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PWM_DIV  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                panel_on_req,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                link_en,
    output logic                led_en,
    output logic                led_pwm,
    output logic                ready,
    output logic [2:0]          pwr_state
);

    localparam int unsigned T_MAX_LB = (T_LINK > T_BL) ? T_LINK : T_BL;
    localparam int unsigned T_MAX    = (T_MAX_LB > T_OFF) ? T_MAX_LB : T_OFF;
    localparam int unsigned CNT_W    = $clog2(T_MAX + 1);
    localparam int unsigned PRE_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    // Counter values on the cycle before the exit edge (exit on the T-th edge after entry)
    localparam logic [CNT_W-1:0]    LINK_LAST = CNT_W'(T_LINK - 1);
    localparam logic [CNT_W-1:0]    BL_LAST   = CNT_W'(T_BL - 1);
    localparam logic [CNT_W-1:0]    OFF_LAST  = CNT_W'(T_OFF - 1);
    localparam logic [CNT_W-1:0]    CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PWM_DIV - 1);
    localparam logic [PRE_W-1:0]    PRE_ZERO  = PRE_W'(0);
    localparam logic [PRE_W-1:0]    PRE_ONE   = PRE_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_ZERO  = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_LINK_WAIT = 3'd1,
        ST_BL_WAIT   = 3'd2,
        ST_ON        = 3'd3,
        ST_BL_OFF    = 3'd4,
        ST_LINK_DOWN = 3'd5,
        ST_OFF_HOLD  = 3'd6
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic                timed_s;

    logic [PRE_W-1:0]    pre_r;
    logic [PRE_W-1:0]    pre_nxt_s;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [PWM_BITS-1:0] pwm_cnt_nxt_s;
    logic [PWM_BITS-1:0] duty_r;
    logic [PWM_BITS-1:0] duty_nxt_s;
    logic                tick_s;
    logic                wrap_s;
    logic                on_entry_s;

    logic                link_en_r;
    logic                led_en_r;
    logic                led_pwm_r;
    logic                ready_r;
    logic                link_en_nxt_s;
    logic                led_en_nxt_s;
    logic                led_pwm_nxt_s;
    logic                ready_nxt_s;

    // Next-state logic; a dropped request aborts power-up, but power-down always completes
    always_comb begin
        state_nxt_s = ST_OFF;
        case (state_r)
            ST_OFF: begin
                if (panel_on_req) state_nxt_s = ST_LINK_WAIT;
                else              state_nxt_s = ST_OFF;
            end
            ST_LINK_WAIT: begin
                if (!panel_on_req)           state_nxt_s = ST_LINK_DOWN;
                else if (cnt_r == LINK_LAST) state_nxt_s = ST_BL_WAIT;
                else                         state_nxt_s = ST_LINK_WAIT;
            end
            ST_BL_WAIT: begin
                if (!panel_on_req)         state_nxt_s = ST_BL_OFF;
                else if (cnt_r == BL_LAST) state_nxt_s = ST_ON;
                else                       state_nxt_s = ST_BL_WAIT;
            end
            ST_ON: begin
                if (!panel_on_req) state_nxt_s = ST_BL_OFF;
                else               state_nxt_s = ST_ON;
            end
            ST_BL_OFF: begin
                if (cnt_r == BL_LAST) state_nxt_s = ST_LINK_DOWN;
                else                  state_nxt_s = ST_BL_OFF;
            end
            ST_LINK_DOWN: begin
                if (cnt_r == LINK_LAST) state_nxt_s = ST_OFF_HOLD;
                else                    state_nxt_s = ST_LINK_DOWN;
            end
            ST_OFF_HOLD: begin
                if (cnt_r == OFF_LAST) state_nxt_s = ST_OFF;
                else                   state_nxt_s = ST_OFF_HOLD;
            end
            default: state_nxt_s = ST_OFF;
        endcase
    end

    // Shared delay counter: cleared on each state entry, idle in untimed states
    always_comb begin
        timed_s   = 1'b0;
        cnt_nxt_s = cnt_r;
        case (state_r)
            ST_LINK_WAIT, ST_BL_WAIT, ST_BL_OFF,
            ST_LINK_DOWN, ST_OFF_HOLD: timed_s = 1'b1;
            default:                   timed_s = 1'b0;
        endcase
        if (state_nxt_s != state_r) cnt_nxt_s = CNT_ZERO;
        else if (timed_s)           cnt_nxt_s = cnt_r + CNT_ONE;
        else                        cnt_nxt_s = CNT_ZERO;
    end

    // PWM prescaler, period counter and duty reload at period start or ON entry
    always_comb begin
        tick_s     = (pre_r == PRE_LAST);
        wrap_s     = tick_s && (pwm_cnt_r == PWM_LAST);
        on_entry_s = (state_nxt_s == ST_ON) && (state_r != ST_ON);
        if (tick_s) begin
            pre_nxt_s     = PRE_ZERO;
            pwm_cnt_nxt_s = pwm_cnt_r + PWM_ONE;
        end else begin
            pre_nxt_s     = pre_r + PRE_ONE;
            pwm_cnt_nxt_s = pwm_cnt_r;
        end
        if (wrap_s || on_entry_s) duty_nxt_s = brightness;
        else                      duty_nxt_s = duty_r;
    end

    // Output decode from the next state so the pins change on the same edge as the state
    always_comb begin
        link_en_nxt_s = 1'b0;
        led_en_nxt_s  = 1'b0;
        ready_nxt_s   = 1'b0;
        case (state_nxt_s)
            ST_LINK_WAIT, ST_LINK_DOWN: begin
                link_en_nxt_s = 1'b1;
            end
            ST_BL_WAIT, ST_BL_OFF: begin
                link_en_nxt_s = 1'b1;
                led_en_nxt_s  = 1'b1;
            end
            ST_ON: begin
                link_en_nxt_s = 1'b1;
                led_en_nxt_s  = 1'b1;
                ready_nxt_s   = 1'b1;
            end
            default: begin
                link_en_nxt_s = 1'b0;
                led_en_nxt_s  = 1'b0;
                ready_nxt_s   = 1'b0;
            end
        endcase
        if (state_nxt_s == ST_ON) led_pwm_nxt_s = (pwm_cnt_nxt_s < duty_nxt_s);
        else                      led_pwm_nxt_s = 1'b0;
    end

    // Sequencer state and delay counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_OFF;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // PWM registers, free-running in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r     <= PRE_ZERO;
            pwm_cnt_r <= PWM_ZERO;
            duty_r    <= PWM_ZERO;
        end else begin
            pre_r     <= pre_nxt_s;
            pwm_cnt_r <= pwm_cnt_nxt_s;
            duty_r    <= duty_nxt_s;
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_en_r <= 1'b0;
            led_en_r  <= 1'b0;
            led_pwm_r <= 1'b0;
            ready_r   <= 1'b0;
        end else begin
            link_en_r <= link_en_nxt_s;
            led_en_r  <= led_en_nxt_s;
            led_pwm_r <= led_pwm_nxt_s;
            ready_r   <= ready_nxt_s;
        end
    end

    assign link_en   = link_en_r;
    assign led_en    = led_en_r;
    assign led_pwm   = led_pwm_r;
    assign ready     = ready_r;
    assign pwr_state = state_r;

endmodule

// File: tb/tb_panel_power_sequencer.sv
// Directed bench for panel_power_sequencer with short timings (T_LINK=4, T_BL=3, T_OFF=5,
// PWM_BITS=4, PWM_DIV=1); outputs are sampled on the falling clock edge.
module tb_panel_power_sequencer;

    logic       clk;
    logic       rst_n;
    logic       panel_on_req;
    logic [3:0] brightness;
    logic       link_en;
    logic       led_en;
    logic       led_pwm;
    logic       ready;
    logic [2:0] pwr_state;

    int n_vec = 0;
    int n_err = 0;

    panel_power_sequencer #(
        .T_LINK   (4),
        .T_BL     (3),
        .T_OFF    (5),
        .PWM_BITS (4),
        .PWM_DIV  (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .panel_on_req (panel_on_req),
        .brightness   (brightness),
        .link_en      (link_en),
        .led_en       (led_en),
        .led_pwm      (led_pwm),
        .ready        (ready),
        .pwr_state    (pwr_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // one rising edge, then sample at the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (led_pwm) c++;
        end
    endtask

    initial begin
        int  c;
        int  c2;
        logic prev;
        logic found;
        logic pwm_seen;

        // 1: reset holds everything low even with the request asserted
        rst_n        = 1'b0;
        panel_on_req = 1'b1;
        brightness   = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check_vec("rst_link_en", link_en, 0);
        check_vec("rst_led_en", led_en, 0);
        check_vec("rst_led_pwm", led_pwm, 0);
        check_vec("rst_ready", ready, 0);
        check_vec("rst_state", pwr_state, 0);
        rst_n = 1'b1;
        tick();
        check_vec("rel_state", pwr_state, 1);
        check_vec("rel_link_en", link_en, 1);
        rst_n        = 1'b0;
        panel_on_req = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        check_vec("idle_state", pwr_state, 0);

        // 2: power-up, edge k
        brightness   = 4'd4;
        panel_on_req = 1'b1;
        tick();
        check_vec("up_k_state", pwr_state, 1);
        check_vec("up_k_link_en", link_en, 1);
        check_vec("up_k_led_en", led_en, 0);
        step(3);
        check_vec("up_k3_led_en", led_en, 0);
        tick();
        check_vec("up_k4_led_en", led_en, 1);
        check_vec("up_k4_state", pwr_state, 2);
        step(2);
        check_vec("up_k6_ready", ready, 0);
        check_vec("up_k6_led_pwm", led_pwm, 0);
        tick();
        check_vec("up_k7_ready", ready, 1);
        check_vec("up_k7_state", pwr_state, 3);

        // 3: PWM duty 4, then a mid-period change to 12
        count_high(16, c);
        check_vec("pwm_duty4", c, 4);
        found = 1'b0;
        prev  = led_pwm;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (!prev && led_pwm) found = 1'b1;
            prev = led_pwm;
        end
        check_vec("pwm_rise_seen", found, 1);
        c = 1;
        tick();
        if (led_pwm) c++;
        brightness = 4'd12;
        count_high(14, c2);
        check_vec("pwm_old_duty_kept", c + c2, 4);
        count_high(16, c);
        check_vec("pwm_new_duty12", c, 12);
        brightness = 4'd0;
        step(16);
        count_high(16, c);
        check_vec("pwm_duty0", c, 0);
        brightness = 4'd15;
        step(16);
        count_high(16, c);
        check_vec("pwm_duty15", c, 15);
        check_vec("pwm_ready_held", ready, 1);

        // 4: power-down from ON, edge m
        panel_on_req = 1'b0;
        tick();
        check_vec("dn_m_led_pwm", led_pwm, 0);
        check_vec("dn_m_ready", ready, 0);
        check_vec("dn_m_state", pwr_state, 4);
        check_vec("dn_m_led_en", led_en, 1);
        step(2);
        check_vec("dn_m2_led_en", led_en, 1);
        tick();
        check_vec("dn_m3_led_en", led_en, 0);
        check_vec("dn_m3_link_en", link_en, 1);
        check_vec("dn_m3_state", pwr_state, 5);
        step(3);
        check_vec("dn_m6_link_en", link_en, 1);
        tick();
        check_vec("dn_m7_link_en", link_en, 0);
        check_vec("dn_m7_state", pwr_state, 6);
        step(4);
        check_vec("dn_m11_state", pwr_state, 6);
        tick();
        check_vec("dn_m12_state", pwr_state, 0);

        // 5: abort during BL_WAIT, then re-request inside OFF_HOLD
        panel_on_req = 1'b1;
        step(5);
        check_vec("ab_blwait_state", pwr_state, 2);
        panel_on_req = 1'b0;
        pwm_seen     = 1'b0;
        tick();
        pwm_seen = pwm_seen | led_pwm;
        check_vec("ab_a_state", pwr_state, 4);
        check_vec("ab_a_led_en", led_en, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            pwm_seen = pwm_seen | led_pwm;
        end
        check_vec("ab_a3_state", pwr_state, 5);
        check_vec("ab_a3_led_en", led_en, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            pwm_seen = pwm_seen | led_pwm;
        end
        check_vec("ab_a7_state", pwr_state, 6);
        check_vec("ab_a7_link_en", link_en, 0);
        check_vec("ab_no_pwm", pwm_seen, 0);
        panel_on_req = 1'b1;
        step(4);
        check_vec("rt_h4_state", pwr_state, 6);
        check_vec("rt_h4_link_en", link_en, 0);
        tick();
        check_vec("rt_h5_state", pwr_state, 0);
        check_vec("rt_h5_link_en", link_en, 0);
        tick();
        check_vec("rt_h6_state", pwr_state, 1);
        check_vec("rt_h6_link_en", link_en, 1);

        // 6: asynchronous reset while ON with the PWM output high
        step(7);
        check_vec("ar_on_state", pwr_state, 3);
        for (int i = 0; i < 3 && !led_pwm; i++) tick();
        check_vec("ar_pwm_before", led_pwm, 1);
        #1 rst_n = 1'b0;
        #1;
        check_vec("ar_link_en", link_en, 0);
        check_vec("ar_led_en", led_en, 0);
        check_vec("ar_led_pwm", led_pwm, 0);
        check_vec("ar_ready", ready, 0);
        check_vec("ar_state", pwr_state, 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
